// File: rtl/text_bitmap_renderer.sv
// text_bitmap_renderer
//   Reader side of the 108x26 text-bitmap ROM. Turns VGA pixel coordinates
//   into a ROM row address, picks the addressed bit out of the returned row
//   word and produces the pixel colour for the text window. Two-stage
//   pipeline (coordinates -> rgb/text_on in exactly 2 clk), with optional
//   per-frame horizontal scrolling (marquee) and blinking.
//
// Ports
//   clk         pixel clock
//   reset       asynchronous, active-high reset
//   pixel_x     current pixel column from the sync generator (10 bit)
//   pixel_y     current pixel row from the sync generator (10 bit)
//   video_on    visible-area flag
//   frame_tick  one-cycle pulse at start of vertical blank
//   scroll_en   advance the scroll offset on each frame_tick
//   blink_en    enable blinking
//   rom_addr    registered ROM row address (5 bit)
//   rom_data    ROM row word, combinational ROM; bit 107 is column 0
//   text_on     registered "text pixel lit" flag
//   rgb         registered 8-bit pixel colour
module text_bitmap_renderer #(
  parameter int unsigned ORIGIN_X     = 266,
  parameter int unsigned ORIGIN_Y     = 227,
  parameter int unsigned TEXT_W       = 108,
  parameter int unsigned TEXT_H       = 26,
  parameter logic [7:0]  FG_COLOR     = 8'hFF,
  parameter logic [7:0]  BG_COLOR     = 8'h00,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic                video_on,
  input  logic                frame_tick,
  input  logic                scroll_en,
  input  logic                blink_en,
  output logic [4:0]          rom_addr,
  input  logic [TEXT_W-1:0]   rom_data,
  output logic                text_on,
  output logic [7:0]          rgb
);

  localparam int unsigned CNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Stage 1 state
  logic             r_in_box_s1;
  logic [6:0]       r_col_s1;
  logic [4:0]       r_rom_addr;

  // Stage 2 state
  logic             r_text_on;
  logic [7:0]       r_rgb;

  // Per-frame counters
  logic [6:0]       r_scroll_off;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_vis;

  // Combinational stage-1 terms
  logic             w_in_box;
  logic [6:0]       w_dx;
  logic [4:0]       w_dy;
  logic [7:0]       w_sum;
  logic [7:0]       w_col;

  // Combinational stage-2 terms
  logic [6:0]       w_idx;
  logic             w_bit;
  logic             w_lit;

  // Window test is done on full-width coordinates before any subtraction,
  // so columns left of the window can never alias into it.
  always_comb begin
    w_in_box = video_on
             && (32'(pixel_x) >= ORIGIN_X) && (32'(pixel_x) < ORIGIN_X + TEXT_W)
             && (32'(pixel_y) >= ORIGIN_Y) && (32'(pixel_y) < ORIGIN_Y + TEXT_H);
    // Inside the window the offsets are < 128 / < 32, so the low bits of
    // the modular difference are exact.
    w_dx  = pixel_x[6:0] - 7'(ORIGIN_X);
    w_dy  = pixel_y[4:0] - 5'(ORIGIN_Y);
    // dx + scroll_off < 2*TEXT_W, so one conditional subtract is the modulo.
    w_sum = {1'b0, w_dx} + {1'b0, r_scroll_off};
    w_col = (w_sum >= 8'(TEXT_W)) ? (w_sum - 8'(TEXT_W)) : w_sum;
  end

  always_comb begin
    w_idx = 7'(TEXT_W - 1) - r_col_s1;
    w_bit = rom_data[w_idx];
    w_lit = r_in_box_s1 & w_bit & (r_blink_vis | ~blink_en);
  end

  // Pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_box_s1 <= 1'b0;
      r_col_s1    <= '0;
      r_rom_addr  <= '0;
      r_text_on   <= 1'b0;
      r_rgb       <= BG_COLOR;
    end else begin
      r_in_box_s1 <= w_in_box;
      if (w_in_box) begin
        r_rom_addr <= w_dy;
        r_col_s1   <= w_col[6:0];
      end else begin
        r_rom_addr <= '0;
        r_col_s1   <= '0;
      end
      r_text_on <= w_lit;
      r_rgb     <= w_lit ? FG_COLOR : BG_COLOR;
    end
  end

  // Scroll and blink counters advance only on frame_tick; pixels already in
  // stage 1 keep the column computed with the previous offset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scroll_off <= '0;
      r_blink_cnt  <= '0;
      r_blink_vis  <= 1'b1;
    end else if (frame_tick) begin
      if (scroll_en) begin
        if (r_scroll_off == 7'(TEXT_W - 1)) begin
          r_scroll_off <= '0;
        end else begin
          r_scroll_off <= r_scroll_off + 7'd1;
        end
      end
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_vis <= ~r_blink_vis;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign rom_addr = r_rom_addr;
  assign text_on  = r_text_on;
  assign rgb      = r_rgb;

endmodule
